// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams,
// with optional packet locking and deferred bit-period updates.
`timescale 1ns/1ps

module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter bit LOCK_PACKETS = 1'b1,
    parameter int CNT_W        = 32,
    localparam int GW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic                 cfg_wr_i,
    input  logic [15:0]          cfg_bit_period_i,
    output logic                 cfg_pending_o,
    output logic                 tx_en_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_busy_i,
    output logic                 wr_bit_period_o,
    output logic [15:0]          bit_period_o,
    output logic [GW-1:0]        grant_o,
    output logic                 locked_o,
    output logic [CNT_W-1:0]     tx_count_o
);

    // state     | meaning
    // ARB       | pick next requester, or divert to CFG when a period change is due
    // CFG       | one-cycle bit-period write strobe to the UART
    // ISSUE     | one-cycle tx_en pulse with the captured byte
    // WAIT_BUSY | wait for the UART to report busy
    // WAIT_DONE | wait for the UART to finish the frame
    typedef enum logic [2:0] {
        ARB       = 3'd0,
        CFG       = 3'd1,
        ISSUE     = 3'd2,
        WAIT_BUSY = 3'd3,
        WAIT_DONE = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [GW-1:0]    ptr_q;
    logic [GW-1:0]    grant_q;
    logic [7:0]       data_q;
    logic             last_q;
    logic             lock_q;
    logic [CNT_W-1:0] count_q;
    logic [15:0]      cfg_store_q;
    logic             cfg_pending_q;
    logic [15:0]      applied_q;

    logic             found;
    logic [GW-1:0]    pick;
    logic [GW-1:0]    pick_next;
    logic             accept;

    // Eligible requester: the locked one, else first valid at or after the pointer.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        if (lock_q) begin
            found = req_valid_i[grant_q];
            pick  = grant_q;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!found && req_valid_i[idx]) begin
                    found = 1'b1;
                    pick  = GW'(idx);
                end
            end
        end
    end

    assign pick_next = (pick == GW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;

    always_comb begin
        state_d         = state_q;
        req_ready_o     = '0;
        tx_en_o         = 1'b0;
        wr_bit_period_o = 1'b0;
        accept          = 1'b0;
        case (state_q)
            ARB: begin
                if (cfg_pending_q && !lock_q && !tx_busy_i) begin
                    state_d = CFG;
                end else if (found && !tx_busy_i) begin
                    accept            = 1'b1;
                    req_ready_o[pick] = 1'b1;
                    state_d           = ISSUE;
                end
            end
            CFG: begin
                wr_bit_period_o = 1'b1;
                state_d         = ARB;
            end
            ISSUE: begin
                tx_en_o = 1'b1;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy_i) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy_i) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ARB;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q         <= '0;
            grant_q       <= '0;
            data_q        <= '0;
            last_q        <= 1'b0;
            lock_q        <= 1'b0;
            count_q       <= '0;
            cfg_store_q   <= '0;
            cfg_pending_q <= 1'b0;
            applied_q     <= '0;
        end else begin
            if (accept) begin
                data_q  <= req_data_i[8*pick +: 8];
                last_q  <= req_last_i[pick];
                grant_q <= pick;
                ptr_q   <= pick_next;
            end
            if (state_q == ISSUE) begin
                count_q <= count_q + 1'b1;
                lock_q  <= LOCK_PACKETS & ~last_q;
            end
            if (state_q == CFG) applied_q <= cfg_store_q;
            // A write landing in the CFG cycle stays pending for another visit.
            if (cfg_wr_i) begin
                cfg_store_q   <= cfg_bit_period_i;
                cfg_pending_q <= 1'b1;
            end else if (state_q == CFG) begin
                cfg_pending_q <= 1'b0;
            end
        end
    end

    assign tx_data_o     = data_q;
    assign grant_o       = grant_q;
    assign locked_o      = lock_q;
    assign tx_count_o    = count_q;
    assign cfg_pending_o = cfg_pending_q;
    assign bit_period_o  = (state_q == CFG) ? cfg_store_q : applied_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, a busy-pulse UART model and
// an ordered scoreboard of expected tx_en / wr_bit_period events.
`timescale 1ns/1ps

module tb_uart_tx_arbiter;
    localparam int N        = 4;
    localparam int BUSY_LEN = 6;

    int checks = 0;
    int errors = 0;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*8-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           cfg_wr = 1'b0;
    logic [15:0]    cfg_bp = '0;
    logic           cfg_pending;
    logic           tx_en;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic           wr_bp;
    logic [15:0]    bp;
    logic [1:0]     grant;
    logic           locked;
    logic [31:0]    tx_count;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .LOCK_PACKETS(1'b1), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
        .req_ready_o(req_ready),
        .cfg_wr_i(cfg_wr), .cfg_bit_period_i(cfg_bp), .cfg_pending_o(cfg_pending),
        .tx_en_o(tx_en), .tx_data_o(tx_data), .tx_busy_i(tx_busy),
        .wr_bit_period_o(wr_bp), .bit_period_o(bp),
        .grant_o(grant), .locked_o(locked), .tx_count_o(tx_count)
    );

    typedef struct packed {
        logic        is_cfg;
        logic [1:0]  g;
        logic [7:0]  d;
        logic        lk;
        logic [15:0] p;
    } ev_t;

    ev_t        sb[$];
    logic [8:0] rq[N][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int r, input logic last, input logic [7:0] d);
        rq[r].push_back({last, d});
    endtask

    task automatic exp_byte(input logic [1:0] g, input logic [7:0] d, input logic lk);
        sb.push_back('{is_cfg: 1'b0, g: g, d: d, lk: lk, p: 16'h0});
    endtask

    task automatic exp_cfg(input logic [15:0] p);
        sb.push_back('{is_cfg: 1'b1, g: 2'd0, d: 8'h0, lk: 1'b0, p: p});
    endtask

    // Requesters: pop a byte after the edge at which it was accepted.
    logic [N-1:0] rdy_s;
    always begin
        @(negedge clk);
        rdy_s = req_ready;
        @(posedge clk);
        #2;
        for (int i = 0; i < N; i++) begin
            if (rdy_s[i] && rq[i].size() > 0 && rst_n) void'(rq[i].pop_front());
            if (rq[i].size() > 0) begin
                req_valid[i]      = 1'b1;
                req_last[i]       = rq[i][0][8];
                req_data[8*i +: 8] = rq[i][0][7:0];
            end else begin
                req_valid[i]      = 1'b0;
                req_last[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
            end
        end
    end

    // UART model: busy rises the cycle after tx_en and stays high BUSY_LEN cycles.
    int   busy_cnt = 0;
    logic en_s;
    always begin
        @(negedge clk);
        en_s = tx_en;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            busy_cnt = 0;
        end else if (en_s) begin
            busy_cnt = BUSY_LEN;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
        end
        tx_busy = (busy_cnt > 0);
    end

    // Scoreboard monitor.
    int   n_en = 0;
    logic lk_chk = 1'b0;
    logic lk_exp = 1'b0;
    ev_t  e;
    always @(negedge clk) begin
        if (lk_chk) begin
            chk("locked_after_issue", locked, lk_exp);
            lk_chk = 1'b0;
        end
        if (tx_en) begin
            n_en++;
            chk("tx_en_expected", sb.size() > 0, 1);
            chk("en_while_busy", tx_busy, 0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("event_kind_en", e.is_cfg, 0);
                chk("tx_data", tx_data, e.d);
                chk("grant", grant, e.g);
                lk_exp = e.lk;
                lk_chk = 1'b1;
            end
        end
        if (wr_bp) begin
            chk("wr_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("event_kind_wr", e.is_cfg, 1);
                chk("bit_period", bp, e.p);
            end
        end
    end

    task automatic wait_en(input int target);
        int budget;
        budget = 300;
        while (n_en < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("wait_en_timeout", n_en >= target, 1);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 500;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("idle_timeout", sb.size(), 0);
        repeat (BUSY_LEN + 4) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_tx_en"}, tx_en, 0);
        chk({tag, "_wr_bp"}, wr_bp, 0);
        chk({tag, "_tx_count"}, tx_count, 0);
        chk({tag, "_grant"}, grant, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_cfg_pending"}, cfg_pending, 0);
        chk({tag, "_bit_period"}, bp, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_ready"}, req_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int budget;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single byte from req0
        req(0, 1'b1, 8'hA5);
        exp_byte(2'd0, 8'hA5, 1'b0);
        budget = 50;
        while (!req_ready[0] && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("t1_ready", req_ready, 4'b0001);
        @(negedge clk);
        chk("t1_tx_en", tx_en, 1);
        chk("t1_tx_data", tx_data, 8'hA5);
        chk("t1_ready_one_cycle", req_ready, 0);
        @(negedge clk);
        chk("t1_tx_count", tx_count, 1);
        chk("t1_grant", grant, 0);
        chk("t1_en_one_cycle", tx_en, 0);
        wait_idle();

        // 2: round robin over req1..3, pointer sits at 1
        req(1, 1'b1, 8'h21); req(1, 1'b1, 8'h24);
        req(2, 1'b1, 8'h22); req(2, 1'b1, 8'h25);
        req(3, 1'b1, 8'h23); req(3, 1'b1, 8'h26);
        exp_byte(2'd1, 8'h21, 1'b0); exp_byte(2'd2, 8'h22, 1'b0); exp_byte(2'd3, 8'h23, 1'b0);
        exp_byte(2'd1, 8'h24, 1'b0); exp_byte(2'd2, 8'h25, 1'b0); exp_byte(2'd3, 8'h26, 1'b0);
        wait_idle();
        chk("t2_tx_count", tx_count, 7);

        // 3: locked packet from req0 holds off req1
        req(0, 1'b0, 8'h10); req(0, 1'b0, 8'h11); req(0, 1'b1, 8'h12);
        req(1, 1'b1, 8'h20);
        exp_byte(2'd0, 8'h10, 1'b1); exp_byte(2'd0, 8'h11, 1'b1);
        exp_byte(2'd0, 8'h12, 1'b0); exp_byte(2'd1, 8'h20, 1'b0);
        wait_idle();
        chk("t3_locked_end", locked, 0);

        // 4: baud change inside a locked packet applies after the packet
        n0 = n_en;
        req(2, 1'b0, 8'h30); req(2, 1'b1, 8'h31);
        req(3, 1'b1, 8'h40);
        exp_byte(2'd2, 8'h30, 1'b1); exp_byte(2'd2, 8'h31, 1'b0);
        exp_cfg(16'h0035);
        exp_byte(2'd3, 8'h40, 1'b0);
        wait_en(n0 + 1);
        @(posedge clk); #1;
        cfg_wr = 1'b1; cfg_bp = 16'h0035;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        @(negedge clk);
        chk("t4_cfg_pending", cfg_pending, 1);
        chk("t4_bp_unchanged", bp, 0);
        wait_idle();
        chk("t4_cfg_cleared", cfg_pending, 0);
        chk("t4_bp_applied", bp, 16'h0035);

        // 5: two writes while busy, last one wins
        n0 = n_en;
        req(0, 1'b1, 8'h50);
        exp_byte(2'd0, 8'h50, 1'b0);
        exp_cfg(16'h0200);
        wait_en(n0 + 1);
        @(posedge clk); #1;
        chk("t5_busy", tx_busy, 1);
        cfg_wr = 1'b1; cfg_bp = 16'h0100;
        @(posedge clk); #1;
        cfg_bp = 16'h0200;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
        wait_idle();
        chk("t5_bp", bp, 16'h0200);
        chk("t5_cfg_cleared", cfg_pending, 0);
        chk("t5_tx_count", tx_count, 15);

        // 6: reset during WAIT_DONE
        n0 = n_en;
        req(1, 1'b1, 8'h60);
        exp_byte(2'd1, 8'h60, 1'b0);
        wait_en(n0 + 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_busy_before_reset", tx_busy, 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("t6_count_after", tx_count, 0);
        chk("t6_en_after", tx_en, 0);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
